// File: rtl/game_state_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : game_state_keeper
//  Description : Live Sokoban board state. It executes load, move/push and
//                retract commands and keeps a bounded circular undo history
//                and a step counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_state_keeper #(
    parameter int HIST_DEPTH = 8,
    parameter int HIST_AW    = 3,
    parameter int STEP_W     = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                game_state_en,
    input  logic [1:0]          sel,
    input  logic [63:0]         level_way,
    input  logic [63:0]         level_box,
    input  logic [5:0]          level_player,
    input  logic [5:0]          cursor,
    output logic [133:0]        game_state,
    output logic                move_result,
    output logic [HIST_AW:0]    hist_count,
    output logic [STEP_W-1:0]   step_count
);

    localparam logic [1:0]       c_SEL_LOAD    = 2'b00;
    localparam logic [1:0]       c_SEL_MOVE    = 2'b01;
    localparam logic [1:0]       c_SEL_RETRACT = 2'b11;
    localparam int               c_ENTRY_W     = 70;
    localparam logic [HIST_AW:0] c_HIST_FULL   = (HIST_AW+1)'(HIST_DEPTH);
    localparam logic [STEP_W-1:0] c_STEP_MAX   = {STEP_W{1'b1}};

    // Registered board, counters and history
    logic [63:0]          way_q,    way_d;
    logic [63:0]          box_q,    box_d;
    logic [5:0]           player_q, player_d;
    logic [HIST_AW-1:0]   ptr_q,    ptr_d;
    logic [HIST_AW:0]     hist_q,   hist_d;
    logic [STEP_W-1:0]    step_q,   step_d;
    logic [c_ENTRY_W-1:0] mem_q [HIST_DEPTH];

    // Combinational helpers
    logic [3:0]           w_pr, w_pc, w_tr, w_tc;
    logic                 w_right, w_left, w_down, w_up, w_adj;
    logic                 w_beyond_ok;
    logic [5:0]           w_beyond;
    logic                 w_way_t, w_box_t, w_way_b, w_box_b;
    logic                 w_move_ok;
    logic [HIST_AW-1:0]   w_rd_ptr;
    logic [c_ENTRY_W-1:0] w_rd_entry;
    logic                 w_mem_we;

    // Row/column split, zero-extended so +1 never wraps back onto the board
    assign w_pr = {1'b0, player_q[5:3]};
    assign w_pc = {1'b0, player_q[2:0]};
    assign w_tr = {1'b0, cursor[5:3]};
    assign w_tc = {1'b0, cursor[2:0]};

    assign w_right = (w_tr == w_pr) && (w_tc == w_pc + 4'd1);
    assign w_left  = (w_tr == w_pr) && (w_pc == w_tc + 4'd1);
    assign w_down  = (w_tc == w_pc) && (w_tr == w_pr + 4'd1);
    assign w_up    = (w_tc == w_pc) && (w_pr == w_tr + 4'd1);
    assign w_adj   = w_right | w_left | w_down | w_up;

    // Beyond cell of a push: one more step in the same direction, on board
    always_comb begin
        w_beyond    = cursor;
        w_beyond_ok = 1'b0;
        if (w_right) begin
            w_beyond    = cursor + 6'd1;
            w_beyond_ok = (w_tc != 4'd7);
        end else if (w_left) begin
            w_beyond    = cursor - 6'd1;
            w_beyond_ok = (w_tc != 4'd0);
        end else if (w_down) begin
            w_beyond    = cursor + 6'd8;
            w_beyond_ok = (w_tr != 4'd7);
        end else if (w_up) begin
            w_beyond    = cursor - 6'd8;
            w_beyond_ok = (w_tr != 4'd0);
        end
    end

    assign w_way_t = way_q[cursor];
    assign w_box_t = box_q[cursor];
    assign w_way_b = way_q[w_beyond];
    assign w_box_b = box_q[w_beyond];

    assign w_move_ok = w_adj &&
                       ((w_way_t && !w_box_t) ||
                        (w_box_t && w_beyond_ok && w_way_b && !w_box_b));

    // Newest history entry sits just below the write pointer
    assign w_rd_ptr   = ptr_q - HIST_AW'(1);
    assign w_rd_entry = mem_q[w_rd_ptr];

    // Command decode and next-state computation
    always_comb begin
        way_d    = way_q;
        box_d    = box_q;
        player_d = player_q;
        ptr_d    = ptr_q;
        hist_d   = hist_q;
        step_d   = step_q;
        w_mem_we = 1'b0;
        if (game_state_en) begin
            case (sel)
                c_SEL_LOAD: begin
                    way_d    = level_way;
                    box_d    = level_box;
                    player_d = level_player;
                    ptr_d    = '0;
                    hist_d   = '0;
                    step_d   = '0;
                end
                c_SEL_MOVE: begin
                    if (w_move_ok) begin
                        w_mem_we = 1'b1;
                        player_d = cursor;
                        if (w_box_t) begin
                            box_d[cursor]   = 1'b0;
                            box_d[w_beyond] = 1'b1;
                        end
                        ptr_d = ptr_q + HIST_AW'(1);
                        if (hist_q != c_HIST_FULL)
                            hist_d = hist_q + 1'b1;
                        if (step_q != c_STEP_MAX)
                            step_d = step_q + 1'b1;
                    end
                end
                c_SEL_RETRACT: begin
                    if (hist_q != '0) begin
                        box_d    = w_rd_entry[69:6];
                        player_d = w_rd_entry[5:0];
                        ptr_d    = w_rd_ptr;
                        hist_d   = hist_q - 1'b1;
                        if (step_q != '0)
                            step_d = step_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Board and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            way_q    <= '0;
            box_q    <= '0;
            player_q <= '0;
            ptr_q    <= '0;
            hist_q   <= '0;
            step_q   <= '0;
        end else begin
            way_q    <= way_d;
            box_q    <= box_d;
            player_q <= player_d;
            ptr_q    <= ptr_d;
            hist_q   <= hist_d;
            step_q   <= step_d;
        end
    end

    // Undo history: pre-move {box, player} written at the write pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < HIST_DEPTH; i++)
                mem_q[i] <= '0;
        end else if (w_mem_we) begin
            mem_q[ptr_q] <= {box_q, player_q};
        end
    end

    assign game_state  = {way_q, box_q, player_q};
    assign move_result = w_move_ok;
    assign hist_count  = hist_q;
    assign step_count  = step_q;

endmodule
`default_nettype wire

// File: tb/tb_game_state_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_state_keeper
//  Description : Directed self-checking bench for game_state_keeper.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_state_keeper;

    localparam logic [63:0] c_ONES = {64{1'b1}};

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         game_state_en = 1'b0;
    logic [1:0]   sel = 2'b00;
    logic [63:0]  level_way = '0;
    logic [63:0]  level_box = '0;
    logic [5:0]   level_player = '0;
    logic [5:0]   cursor = '0;
    logic [133:0] game_state;
    logic         move_result;
    logic [3:0]   hist_count;
    logic [9:0]   step_count;

    int n_err = 0;
    int n_chk = 0;

    game_state_keeper #(.HIST_DEPTH(8), .HIST_AW(3), .STEP_W(10)) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .game_state_en (game_state_en),
        .sel           (sel),
        .level_way     (level_way),
        .level_box     (level_box),
        .level_player  (level_player),
        .cursor        (cursor),
        .game_state    (game_state),
        .move_result   (move_result),
        .hist_count    (hist_count),
        .step_count    (step_count)
    );

    always #5 clk = ~clk;

    function automatic logic [133:0] gs(input logic [63:0] w, input logic [63:0] b,
                                        input logic [5:0] p);
        return {w, b, p};
    endfunction

    function automatic logic [63:0] bit64(input int idx);
        logic [63:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe one command; returns on the following falling edge
    task automatic cmd(input logic [1:0] s);
        @(negedge clk);
        sel = s;
        game_state_en = 1'b1;
        @(negedge clk);
        game_state_en = 1'b0;
        #1;
    endtask

    task automatic load(input logic [63:0] w, input logic [63:0] b, input logic [5:0] p);
        level_way = w;
        level_box = b;
        level_player = p;
        cmd(2'b00);
    endtask

    task automatic mv(input logic [5:0] c);
        cursor = c;
        cmd(2'b01);
    endtask

    task automatic probe(input logic [5:0] c);
        cursor = c;
        #1;
    endtask

    logic [5:0] path [10];

    initial begin
        path = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd15, 6'd14, 6'd13};

        // Power-up reset: everything zero while low
        #1 reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_state", game_state, '0);
            check("rst_mr", move_result, 1'b0);
            check("rst_cnt", {hist_count, step_count}, '0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        // Simple move
        load(c_ONES, '0, 6'd9);
        check("load9", game_state, gs(c_ONES, '0, 6'd9));
        probe(6'd10);
        check("mr_9_10", move_result, 1'b1);
        mv(6'd10);
        check("move_state", game_state, gs(c_ONES, '0, 6'd10));
        check("move_step", step_count, 10'd1);
        check("move_hist", hist_count, 4'd1);

        // Idle and reserved command leave state alone
        probe(6'd11);
        sel = 2'b01;
        repeat (2) @(negedge clk);
        check("idle_state", game_state, gs(c_ONES, '0, 6'd10));
        cmd(2'b10);
        check("rsvd_state", game_state, gs(c_ONES, '0, 6'd10));
        check("rsvd_cnt", {hist_count, step_count}, {4'd1, 10'd1});

        // Push, then retract restores the box
        load(c_ONES, bit64(11), 6'd10);
        probe(6'd11);
        check("mr_push", move_result, 1'b1);
        mv(6'd11);
        check("push_state", game_state, gs(c_ONES, bit64(12), 6'd11));
        cmd(2'b11);
        check("unpush_state", game_state, gs(c_ONES, bit64(11), 6'd10));
        check("unpush_cnt", {hist_count, step_count}, '0);

        // Blocked push
        load(c_ONES, bit64(11) | bit64(12), 6'd10);
        probe(6'd11);
        check("mr_blocked", move_result, 1'b0);
        mv(6'd11);
        check("blocked_state", game_state, gs(c_ONES, bit64(11) | bit64(12), 6'd10));
        check("blocked_cnt", {hist_count, step_count}, '0);

        // Walls block plain moves
        load(c_ONES & ~bit64(11), '0, 6'd10);
        probe(6'd11);
        check("mr_wall", move_result, 1'b0);

        // Edge crossing and adjacency boundaries
        load(c_ONES, '0, 6'd7);
        probe(6'd8);
        check("mr_7_8", move_result, 1'b0);
        load(c_ONES, bit64(7), 6'd15);
        probe(6'd7);
        check("mr_push_off", move_result, 1'b0);
        probe(6'd15);
        check("mr_self", move_result, 1'b0);
        probe(6'd14);
        check("mr_15_14", move_result, 1'b1);
        probe(6'd17);
        check("mr_nonadj", move_result, 1'b0);
        probe(6'd23);
        check("mr_15_23", move_result, 1'b1);

        // History overflow and full unwind
        load(c_ONES, '0, 6'd0);
        for (int i = 0; i < 10; i++)
            mv(path[i]);
        check("ovf_state", game_state, gs(c_ONES, '0, 6'd13));
        check("ovf_hist", hist_count, 4'd8);
        check("ovf_step", step_count, 10'd10);
        cmd(2'b11);
        check("ret1_state", game_state, gs(c_ONES, '0, 6'd14));
        check("ret1_cnt", {hist_count, step_count}, {4'd7, 10'd9});
        for (int i = 0; i < 7; i++)
            cmd(2'b11);
        check("ret8_state", game_state, gs(c_ONES, '0, 6'd2));
        check("ret8_cnt", {hist_count, step_count}, {4'd0, 10'd2});
        cmd(2'b11);
        check("ret9_state", game_state, gs(c_ONES, '0, 6'd2));
        check("ret9_cnt", {hist_count, step_count}, {4'd0, 10'd2});

        // Retry after a few moves
        load(c_ONES, bit64(40), 6'd9);
        mv(6'd10);
        mv(6'd11);
        mv(6'd12);
        check("pre_retry", game_state, gs(c_ONES, bit64(40), 6'd12));
        load(c_ONES, bit64(40), 6'd9);
        check("retry_state", game_state, gs(c_ONES, bit64(40), 6'd9));
        check("retry_cnt", {hist_count, step_count}, '0);
        cmd(2'b11);
        check("retry_ret", game_state, gs(c_ONES, bit64(40), 6'd9));
        check("retry_ret_cnt", {hist_count, step_count}, '0);

        // Asynchronous reset mid-run
        mv(6'd10);
        #2 reset_n = 1'b0;
        #1;
        check("async_state", game_state, '0);
        check("async_cnt", {hist_count, step_count}, '0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hold_state", game_state, '0);
            check("hold_mr", move_result, 1'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        cmd(2'b11);
        check("post_rst_ret", {game_state, hist_count, step_count}, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_state_keeper.md
Name: game_state_keeper

Overview:
- Holds the live Sokoban board state and executes the commands issued by the game controller.
- Commands are level load, player move/push and retract (undo).
- Drives the 134-bit game_state bus and the combinational move_result legality flag back to the controller.
- Keeps a bounded circular undo history and a step counter.

Parameters:
HIST_DEPTH  8   number of undo entries kept (power of two)
HIST_AW     3   log2(HIST_DEPTH)
STEP_W      10  step counter width

Ports:
clk           in   1    system clock
reset_n       in   1    asynchronous active-low reset
game_state_en in   1    command strobe from controller, one cycle
sel           in   2    command: 00 load, 01 move, 11 retract, 10 reserved
level_way     in   64   floor map of current level from level ROM (1 = walkable)
level_box     in   64   initial box map from level ROM
level_player  in   6    initial player cell from level ROM
cursor        in   6    target cell selected by user
game_state    out  134  {way[63:0], box[63:0], player[5:0]}
move_result   out  1    1 = cursor move from current state is legal
hist_count    out  HIST_AW+1  valid undo entries, 0..HIST_DEPTH
step_count    out  STEP_W     moves made in current level

Behaviour:
- Reset and one clock:
  - Single clk domain.
  - reset_n low asynchronously clears game_state, hist_count, step_count, history pointer and memory to 0.
  - move_result is then 0, because way = 0.
- Board encoding:
  - 8x8 board; cell index = row*8 + col; row = idx[5:3], col = idx[2:0].
- move_result (combinational from registered state and cursor):
  - Let p = player, t = cursor.
  - Adjacency: t is adjacent when either
    - same row and |col diff| = 1, or
    - same col and |row diff| = 1.
  - Moves that cross a row edge (e.g. 7 -> 8) are not adjacent.
  - t == p gives 0. Any non-adjacent t gives 0.
  - Plain move: way[t]=1 and box[t]=0 gives 1.
  - Push: box[t]=1. The beyond cell b = t + (t - p) must lie on the board in the same row/col direction (no edge crossing). Result is 1 only if way[b]=1 and box[b]=0.
  - Every other case gives 0.
- Commands:
  - Sampled on the rising clk edge with game_state_en=1. The result is visible on game_state the following cycle.
  - Only one command per strobe.
  - game_state_en=0 leaves all state unchanged.
- Load (sel=00):
  - way<=level_way, box<=level_box, player<=level_player.
  - hist_count<=0, step_count<=0.
  - Used for both first entry and retry.
- Move (sel=01):
  - Re-evaluates move_result. If 0: no change at all.
  - If 1:
    - Push {box, player} (70 bits; way is static) into history.
    - player<=t.
    - For a push: box[t]<=0, box[b]<=1.
    - step_count increments, saturating at all-ones.
- History on move:
  - Circular buffer, write pointer wraps modulo HIST_DEPTH.
  - If hist_count < HIST_DEPTH it increments.
  - If full, the oldest entry is overwritten and hist_count stays HIST_DEPTH.
- Retract (sel=11):
  - hist_count=0: no change.
  - Otherwise, in the same edge:
    - Pop the newest entry and restore box and player.
    - Decrement the pointer (wrapping) and hist_count.
    - step_count decrements, not below 0.
  - way is never altered by retract.
- sel=10: no change.
- Reset mid-operation: asynchronous and overriding. No partial update survives.
- History memory: flops or LUTRAM with a combinational read of entry ptr-1; no extra read latency permitted.

Test Plan:
1. Assert reset_n=0 mid-run, release -> game_state=0, move_result=0, hist_count=0, step_count=0 on every cycle while low.
2. Load with way=all ones, box=0, player=9. Set cursor=10 -> move_result=1. Then strobe sel=01 -> player=10, step_count=1, hist_count=1 next cycle.
3. Player at 10, box at 11, cursor=11, cell 12 floor -> push gives box[11]=0, box[12]=1, player=11. Repeat with box also at 12 -> move_result=0, and a sel=01 strobe leaves state unchanged.
4. Edge crossing: player=7, cursor=8 -> move_result=0. Player=15, box at 7, cursor=7 (beyond cell off-board) -> move_result=0.
5. Overflow: 10 legal moves -> hist_count=8, step_count=10. 8 retracts restore the exact state after move 2, with step_count=2. A 9th retract causes no change and hist_count stays 0.
6. Retry: after 3 moves, sel=00 -> state equals the level ROM inputs, hist_count=0, step_count=0. An immediate retract is a no-op.
